// File: rtl/demux_1to4_reg_pkg.sv
// Shared types and helpers for the one-hot mux/demux family.
package mux_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NUM_CH    = 4;

  typedef enum logic [1:0] {CH_A, CH_B, CH_C, CH_D} chan_e;

  // Per-channel register occupancy.
  typedef enum logic {ST_EMPTY, ST_FULL} chan_st_e;

  // Exactly one bit set.
  function automatic logic is_onehot4(logic [3:0] sel);
    return (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
  endfunction

  // Channel index for a one-hot select; non-one-hot values map to CH_A
  // and must be qualified with is_onehot4 by the caller.
  function automatic chan_e sel_to_chan(logic [3:0] sel);
    case (sel)
      4'b0010: return CH_B;
      4'b0100: return CH_C;
      4'b1000: return CH_D;
      default: return CH_A;
    endcase
  endfunction

endpackage

// File: rtl/demux_1to4_reg_if.sv
// Input handshake, four output channels and error status of demux_1to4_reg.
interface demux_1to4_reg_if #(
  parameter int WIDTH = mux_pkg::WIDTH_DEF,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel_a, sel_b, sel_c, sel_d;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic             valid_a, valid_b, valid_c, valid_d;
  logic             ready_a, ready_b, ready_c, ready_d;
  logic             sel_err;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_data, sel_a, sel_b, sel_c, sel_d,
           ready_a, ready_b, ready_c, ready_d,
    input  in_ready, out_a, out_b, out_c, out_d,
           valid_a, valid_b, valid_c, valid_d, sel_err, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, sel_a, sel_b, sel_c, sel_d,
           ready_a, ready_b, ready_c, ready_d,
    output in_ready, out_a, out_b, out_c, out_d,
           valid_a, valid_b, valid_c, valid_d, sel_err, drop_cnt
  );
endinterface

// File: rtl/demux_1to4_reg_chan.sv
// One-entry valid/ready output register; a write while draining replaces
// the word in place so a channel sustains one word per cycle.
module demux_chan_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);
  chan_st_e st, st_nxt;

  // State and data register; data only moves on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= ST_EMPTY;
      data <= '0;
    end else begin
      st <= st_nxt;
      if (wr) data <= wr_data;
    end
  end

  // Occupancy transitions.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_EMPTY: if (wr)              st_nxt = ST_FULL;
      ST_FULL:  if (rd_ready && !wr) st_nxt = ST_EMPTY;
      default:                       st_nxt = ST_EMPTY;
    endcase
  end

  assign valid      = (st == ST_FULL);
  assign can_accept = !valid || rd_ready;
endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux: one-hot select steers each accepted word into
// one of four channel registers; illegal selects are swallowed and counted.
module demux_1to4_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  demux_1to4_reg_if.slave bus
);
  logic [NUM_CH-1:0]            sel, wr, rd_rdy, vld, can_acc;
  logic [NUM_CH-1:0][WIDTH-1:0] dat;
  logic                         sel_ok, xfer;
  chan_e                        sel_ch;
  logic                         err_q;
  logic [CNT_W-1:0]             cnt_q;

  assign sel    = {bus.sel_d, bus.sel_c, bus.sel_b, bus.sel_a};
  assign rd_rdy = {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a};
  assign sel_ok = is_onehot4(sel);
  assign sel_ch = sel_to_chan(sel);

  // Only the selected channel gates the input; illegal words always drain.
  assign bus.in_ready = sel_ok ? can_acc[sel_ch] : 1'b1;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign wr           = {NUM_CH{xfer && sel_ok}} & sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr[i]),
      .wr_data    (bus.in_data),
      .rd_ready   (rd_rdy[i]),
      .valid      (vld[i]),
      .data       (dat[i]),
      .can_accept (can_acc[i])
    );
  end

  // Sticky error flag and saturating drop counter for illegal selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (xfer && !sel_ok) begin
      err_q <= 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_a    = dat[CH_A];
  assign bus.out_b    = dat[CH_B];
  assign bus.out_c    = dat[CH_C];
  assign bus.out_d    = dat[CH_D];
  assign bus.valid_a  = vld[CH_A];
  assign bus.valid_b  = vld[CH_B];
  assign bus.valid_c  = vld[CH_C];
  assign bus.valid_d  = vld[CH_D];
  assign bus.sel_err  = err_q;
  assign bus.drop_cnt = cnt_q;
endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed bench for demux_1to4_reg.
module tb_demux_1to4_reg;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  demux_1to4_reg_if #(.WIDTH(4), .CNT_W(8)) bus ();
  demux_1to4_reg #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs of that edge are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic [3:0] d);
    bus.in_valid = v;
    {bus.sel_d, bus.sel_c, bus.sel_b, bus.sel_a} = s;
    bus.in_data = d;
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a} = r;
    #1;
  endtask

  function automatic logic [3:0] vlds();
    return {bus.valid_d, bus.valid_c, bus.valid_b, bus.valid_a};
  endfunction

  function automatic logic [3:0] outs(input int i);
    case (i)
      0: return bus.out_a;
      1: return bus.out_b;
      2: return bus.out_c;
      default: return bus.out_d;
    endcase
  endfunction

  task automatic test_reset();
    drive(1'b0, 4'b0000, 4'h0);
    set_ready(4'b1111);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    drive(1'b0, 4'b0001, 4'h0);
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=0000", vlds()); end
    checks++; if ({bus.out_d, bus.out_c, bus.out_b, bus.out_a} !== 16'h0) begin errors++;
      $display("FAIL reset_out got=%h exp=0000", {bus.out_d, bus.out_c, bus.out_b, bus.out_a}); end
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.sel_err); end
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.drop_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_routing();
    logic [3:0] words [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic [3:0] onehot;
    set_ready(4'b1111);
    for (int i = 0; i < 4; i++) begin
      onehot = 4'b0001 << i;
      drive(1'b1, onehot, words[i]);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL route_ready ch=%0d got=%b exp=1", i, bus.in_ready); end
      tick();
      drive(1'b0, 4'b0000, 4'h0);
      checks++; if (outs(i) !== words[i]) begin errors++; $display("FAIL route_data ch=%0d got=%h exp=%h", i, outs(i), words[i]); end
      checks++; if (vlds() !== onehot) begin errors++; $display("FAIL route_valid ch=%0d got=%b exp=%b", i, vlds(), onehot); end
    end
    tick();
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL route_drained got=%b exp=0000", vlds()); end
  endtask

  task automatic test_backpressure();
    set_ready(4'b1101);
    drive(1'b1, 4'b0010, 4'hB);
    tick();
    drive(1'b1, 4'b0010, 4'h3);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", bus.in_ready); end
    checks++; if (bus.valid_b !== 1'b1 || bus.out_b !== 4'hB) begin errors++;
      $display("FAIL bp_hold_b got=%b/%h exp=1/b", bus.valid_b, bus.out_b); end
    drive(1'b1, 4'b1000, 4'hD);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_d_ready got=%b exp=1", bus.in_ready); end
    tick();
    drive(1'b0, 4'b0000, 4'h0);
    checks++; if (bus.valid_d !== 1'b1 || bus.out_d !== 4'hD) begin errors++;
      $display("FAIL bp_d_out got=%b/%h exp=1/d", bus.valid_d, bus.out_d); end
    checks++; if (bus.valid_b !== 1'b1 || bus.out_b !== 4'hB) begin errors++;
      $display("FAIL bp_b_still got=%b/%h exp=1/b", bus.valid_b, bus.out_b); end
    set_ready(4'b1111);
    tick();
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL bp_release got=%b exp=0000", vlds()); end
  endtask

  task automatic test_back_to_back();
    set_ready(4'b1011);
    drive(1'b1, 4'b0100, 4'hC);
    tick();
    drive(1'b0, 4'b0000, 4'h0);
    checks++; if (bus.valid_c !== 1'b1 || bus.out_c !== 4'hC) begin errors++;
      $display("FAIL b2b_fill got=%b/%h exp=1/c", bus.valid_c, bus.out_c); end
    set_ready(4'b1111);
    drive(1'b1, 4'b0100, 4'h5);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", bus.in_ready); end
    tick();
    drive(1'b0, 4'b0000, 4'h0);
    checks++; if (bus.valid_c !== 1'b1 || bus.out_c !== 4'h5) begin errors++;
      $display("FAIL b2b_replace got=%b/%h exp=1/5", bus.valid_c, bus.out_c); end
    tick();
    checks++; if (bus.valid_c !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", bus.valid_c); end
  endtask

  task automatic test_illegal();
    set_ready(4'b1111);
    drive(1'b1, 4'b0101, 4'hF);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ill_multi_ready got=%b exp=1", bus.in_ready); end
    tick();
    drive(1'b1, 4'b0000, 4'h7);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ill_none_ready got=%b exp=1", bus.in_ready); end
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL ill_valid1 got=%b exp=0000", vlds()); end
    tick();
    drive(1'b0, 4'b0000, 4'h0);
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL ill_valid2 got=%b exp=0000", vlds()); end
    checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL ill_err got=%b exp=1", bus.sel_err); end
    checks++; if (bus.drop_cnt !== 8'd2) begin errors++; $display("FAIL ill_cnt got=%0d exp=2", bus.drop_cnt); end
    drive(1'b1, 4'b1111, 4'h9);
    for (int i = 0; i < 300; i++) tick();
    drive(1'b0, 4'b0000, 4'h0);
    checks++; if (bus.drop_cnt !== 8'd255) begin errors++; $display("FAIL ill_sat got=%0d exp=255", bus.drop_cnt); end
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL ill_valid3 got=%b exp=0000", vlds()); end
  endtask

  task automatic test_reset_mid();
    set_ready(4'b0110);
    drive(1'b1, 4'b0001, 4'h1);
    tick();
    drive(1'b1, 4'b1000, 4'h8);
    tick();
    checks++; if (vlds() !== 4'b1001) begin errors++; $display("FAIL rm_full got=%b exp=1001", vlds()); end
    // Write to b during reset: reset must win.
    drive(1'b1, 4'b0010, 4'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 4'b0001, 4'h0);
    checks++; if (vlds() !== 4'b0000) begin errors++; $display("FAIL rm_valid got=%b exp=0000", vlds()); end
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL rm_err got=%b exp=0", bus.sel_err); end
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL rm_cnt got=%0d exp=0", bus.drop_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%b exp=1", bus.in_ready); end
    drive(1'b0, 4'b0000, 4'h0);
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
